// File: rtl/ldtu_gain_sel_ctrl.sv
// ldtu_gain_sel_ctrl: LiTe-DTU input-FIFO read/look-ahead pointers and gain x10/x1 window selection
//   CLK, reset       : clock, asynchronous active-high reset
//   GAIN_SEL_MODE    : 00 window 8, 01 window 16, 10 force x10, 11 force x1
//   ref_sat          : saturation compare of FIFO_g10[ref_ptr]
//   rd_ptr, ref_ptr  : FIFO read address and look-ahead address
//   sel_g1           : 1 selects gain x1 sample
//   mode_change      : one-cycle pulse after the registered mode changes
//   sat_count        : saturating count of gain x1 windows opened
module ldtu_gain_sel_ctrl #(
  parameter int NBitsCnt = 4,
  parameter logic [NBitsCnt-1:0] RdPtrInit = 4'b0111,
  parameter logic [NBitsCnt-1:0] RefSample = 4'b0011,
  parameter logic [NBitsCnt-1:0] RefSample2 = 4'b1000,
  parameter int WinShort = 8,
  parameter int WinLong = 16,
  parameter int NBitsSat = 8
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [1:0]          GAIN_SEL_MODE,
  input  logic                ref_sat,
  output logic [NBitsCnt-1:0] rd_ptr,
  output logic [NBitsCnt-1:0] ref_ptr,
  output logic                sel_g1,
  output logic                mode_change,
  output logic [NBitsSat-1:0] sat_count
);
  typedef enum logic [1:0] {TRACK, FORCE_G10, FORCE_G1} state_t;
  state_t state;
  logic [1:0] mode_q;
  logic [4:0] cnt;
  logic chg, opening;
  logic [4:0] win;
  always_comb begin
    chg = GAIN_SEL_MODE != mode_q;
    win = mode_q == 2'b01 ? 5'(WinLong) : 5'(WinShort);
    // a fresh window opens only when none is running; reloads just extend it
    opening = state == TRACK && !chg && ref_sat && cnt == '0;
    ref_ptr = rd_ptr + (mode_q == 2'b01 ? RefSample2 : RefSample);
    sel_g1 = state == FORCE_G1 || (state == TRACK && cnt != '0);
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_ptr <= RdPtrInit;
      mode_q <= 2'b00;
      state <= TRACK;
      cnt <= '0;
      mode_change <= 1'b0;
      sat_count <= '0;
    end else begin
      rd_ptr <= rd_ptr + 1'b1;
      mode_q <= GAIN_SEL_MODE;
      mode_change <= chg;
      state <= GAIN_SEL_MODE[1] ? (GAIN_SEL_MODE[0] ? FORCE_G1 : FORCE_G10) : TRACK;
      // any mode change flushes the window, so no window survives a mode switch
      cnt <= (state != TRACK || chg) ? '0 : ref_sat ? win : cnt != '0 ? cnt - 1'b1 : cnt;
      if (opening && sat_count != '1) sat_count <= sat_count + 1'b1;
    end
  end
endmodule
